// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction, register-file write control,
// misaligned-load reporting and retired-instruction counting.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic            flush,
    output logic            wb_en,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_index,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr,
    output logic [63:0]     instret
);

    typedef enum logic [1:0] {
        SEL_ALU     = 2'b00,
        SEL_LOAD    = 2'b01,
        SEL_LINK    = 2'b10,
        SEL_ALU_ALT = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic            r_valid;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    wb_sel_e         r_wb_sel;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_mem_rdata;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] r_misalign_addr;
    logic [63:0]     r_instret;

    logic [1:0]      w_lane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic            w_is_load;
    logic            w_misaligned;
    logic            w_misalign;
    logic [XLEN-1:0] w_src;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_wb_sel     <= SEL_ALU;
            r_funct3     <= '0;
            r_alu_result <= '0;
            r_mem_rdata  <= '0;
            r_pc_plus4   <= '0;
        end else begin
            r_valid      <= in_valid & ~flush;
            r_rd         <= in_rd;
            r_rd_we      <= in_rd_we;
            r_wb_sel     <= wb_sel_e'(in_wb_sel);
            r_funct3     <= in_funct3;
            r_alu_result <= in_alu_result;
            r_mem_rdata  <= in_mem_rdata;
            r_pc_plus4   <= in_pc_plus4;
        end
    end

    assign w_lane    = r_alu_result[1:0];
    assign w_byte    = r_mem_rdata[8*w_lane +: 8];
    assign w_half    = w_lane[1] ? r_mem_rdata[31:16] : r_mem_rdata[15:0];
    assign w_is_load = (r_wb_sel == SEL_LOAD);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_load_data  = r_mem_rdata;
        w_misaligned = (w_lane != 2'b00);
        case (r_funct3)
            F3_LB: begin
                w_load_data  = {{(XLEN-8){w_byte[7]}}, w_byte};
                w_misaligned = 1'b0;
            end
            F3_LBU: begin
                w_load_data  = {{(XLEN-8){1'b0}}, w_byte};
                w_misaligned = 1'b0;
            end
            F3_LH: begin
                w_load_data  = {{(XLEN-16){w_half[15]}}, w_half};
                w_misaligned = w_lane[0];
            end
            F3_LHU: begin
                w_load_data  = {{(XLEN-16){1'b0}}, w_half};
                w_misaligned = w_lane[0];
            end
            default: ; // LW and undefined encodings keep the full word
        endcase
    end

    always_comb begin
        w_src = r_alu_result;
        case (r_wb_sel)
            SEL_LOAD: w_src = w_load_data;
            SEL_LINK: w_src = r_pc_plus4;
            default:  w_src = r_alu_result;
        endcase
    end

    assign w_misalign = r_valid & w_is_load & w_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_addr <= '0;
            r_instret       <= '0;
        end else begin
            if (w_misalign)
                r_misalign_addr <= r_alu_result;
            if (r_valid && !w_misalign)
                r_instret <= r_instret + 64'd1;
        end
    end

    assign wb_en         = r_valid & r_rd_we & (r_rd != 5'd0) & ~w_misalign;
    assign wb_data       = r_valid ? w_src : '0;
    assign rd_index      = r_valid ? r_rd : 5'd0;
    assign misalign      = w_misalign;
    assign misalign_addr = r_misalign_addr;
    assign instret       = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single instructions, plus stream, reset and wrap sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_pc_plus4;
    logic        flush;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  rd_index;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic [63:0] instret;

    wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .flush(flush),
        .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index), .misalign(misalign),
        .misalign_addr(misalign_addr), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic        flush;
        logic [4:0]  rd;
        logic        rd_we;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        exp_en;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_mis;
        logic        exp_inc;
    } vec_t;

    vec_t        vecs[14];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_instret;
    logic [31:0] exp_mis_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic fl, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4);
        in_valid = v; flush = fl; in_rd = rd; in_rd_we = we; in_wb_sel = sel;
        in_funct3 = f3; in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc4;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic [31:0] data,
                                 input logic [4:0] rd, input logic mis);
        check({tag, ".wb_en"}, {63'd0, wb_en}, {63'd0, en});
        check({tag, ".wb_data"}, {32'd0, wb_data}, {32'd0, data});
        check({tag, ".rd_index"}, {59'd0, rd_index}, {59'd0, rd});
        check({tag, ".misalign"}, {63'd0, misalign}, {63'd0, mis});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name      v  fl rd  we  sel    f3      alu           rdata         pc4        en data          rd  mis inc
        vecs[0]  = '{"lb",     1, 0, 5,  1, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'h0, 1, 32'hFFFF_FF80, 5,  0, 1};
        vecs[1]  = '{"lhu",    1, 0, 7,  1, 2'b01, 3'b101, 32'h0000_2002, 32'h8001_7FFF, 32'h0, 1, 32'h0000_8001, 7,  0, 1};
        vecs[2]  = '{"lh",     1, 0, 7,  1, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'h0, 1, 32'hFFFF_8001, 7,  0, 1};
        vecs[3]  = '{"lw_mis", 1, 0, 9,  1, 2'b01, 3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF, 9,  1, 0};
        vecs[4]  = '{"x0",     1, 0, 0,  1, 2'b00, 3'b000, 32'h0000_1234, 32'h0,         32'h0, 0, 32'h0000_1234, 0,  0, 1};
        vecs[5]  = '{"flush",  1, 1, 3,  1, 2'b00, 3'b000, 32'h0000_1234, 32'h0,         32'h0, 0, 32'h0,         0,  0, 0};
        vecs[6]  = '{"lbu",    1, 0, 11, 1, 2'b01, 3'b100, 32'h0000_0102, 32'h80FF_1234, 32'h0, 1, 32'h0000_00FF, 11, 0, 1};
        vecs[7]  = '{"lh_lo",  1, 0, 12, 1, 2'b01, 3'b001, 32'h0000_0000, 32'h8001_7FFF, 32'h0, 1, 32'h0000_7FFF, 12, 0, 1};
        vecs[8]  = '{"lh_mis", 1, 0, 13, 1, 2'b01, 3'b001, 32'h0000_4003, 32'h8001_7FFF, 32'h0, 0, 32'hFFFF_8001, 13, 1, 0};
        vecs[9]  = '{"f3_011", 1, 0, 14, 1, 2'b01, 3'b011, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1, 32'hCAFE_F00D, 14, 0, 1};
        vecs[10] = '{"sel11",  1, 0, 2,  1, 2'b11, 3'b000, 32'h0000_0055, 32'h1111_1111, 32'h9, 1, 32'h0000_0055, 2,  0, 1};
        vecs[11] = '{"bubble", 0, 0, 15, 1, 2'b00, 3'b000, 32'h0000_0066, 32'h0,         32'h0, 0, 32'h0,         0,  0, 0};
        vecs[12] = '{"no_we",  1, 0, 4,  0, 2'b00, 3'b000, 32'h0000_0077, 32'h0,         32'h0, 0, 32'h0000_0077, 4,  0, 1};
        vecs[13] = '{"lw",     1, 0, 10, 1, 2'b01, 3'b010, 32'h0000_0008, 32'h1234_5678, 32'h0, 1, 32'h1234_5678, 10, 0, 1};

        rst_n = 1'b0;
        idle();
        exp_instret  = 64'd0;
        exp_mis_addr = 32'd0;
        #2;
        check_outputs("reset", 1'b0, 32'h0, 5'd0, 1'b0);
        check("reset.instret", instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].flush, vecs[i].rd, vecs[i].rd_we, vecs[i].wb_sel,
                  vecs[i].funct3, vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
            @(posedge clk); #1;
            check_outputs(vecs[i].name, vecs[i].exp_en, vecs[i].exp_data, vecs[i].exp_rd, vecs[i].exp_mis);
            check({vecs[i].name, ".instret_hold"}, instret, exp_instret);
            @(negedge clk);
            idle();
            @(posedge clk); #1;
            if (vecs[i].exp_inc) exp_instret = exp_instret + 64'd1;
            if (vecs[i].exp_mis) exp_mis_addr = vecs[i].alu;
            check({vecs[i].name, ".instret"}, instret, exp_instret);
            check({vecs[i].name, ".mis_after"}, {63'd0, misalign}, 64'd0);
            check({vecs[i].name, ".mis_addr"}, {32'd0, misalign_addr}, {32'd0, exp_mis_addr});
        end

        // JAL followed by three ALU ops, one capture per edge
        begin
            logic [63:0] base;
            logic [31:0] s_data[4];
            logic [4:0]  s_rd[4];
            base = exp_instret;
            s_data[0] = 32'h0000_0104; s_rd[0] = 5'd1;
            s_data[1] = 32'h0000_0AA1; s_rd[1] = 5'd20;
            s_data[2] = 32'h0000_0BB2; s_rd[2] = 5'd21;
            s_data[3] = 32'h0000_0CC3; s_rd[3] = 5'd22;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (i == 0) drive(1'b1, 1'b0, s_rd[0], 1'b1, 2'b10, 3'b000, 32'h0000_5000, 32'h0, s_data[0]);
                else        drive(1'b1, 1'b0, s_rd[i], 1'b1, 2'b00, 3'b000, s_data[i], 32'h0, 32'h0000_0999);
                @(posedge clk); #1;
                check($sformatf("stream%0d", i), {26'd0, wb_en, rd_index, wb_data}, {26'd0, 1'b1, s_rd[i], s_data[i]});
                check($sformatf("stream%0d.instret", i), instret, base + 64'(i));
            end
            @(negedge clk);
            idle();
            @(posedge clk); #1;
            exp_instret = base + 64'd4;
            check("stream.instret", instret, exp_instret);
            check("stream.idle_en", {63'd0, wb_en}, 64'd0);
        end

        // Asynchronous reset while a valid instruction sits in WB
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd6, 1'b1, 2'b00, 3'b000, 32'h0000_0099, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("pre_rst.wb_en", {63'd0, wb_en}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 5'd0, 1'b0);
        check("async_rst.instret", instret, 64'd0);
        check("async_rst.mis_addr", {32'd0, misalign_addr}, 64'd0);
        idle();
        exp_instret = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst.instret", instret, 64'd0);
        check("post_rst.wb_en", {63'd0, wb_en}, 64'd0);

        @(negedge clk);
        drive(1'b1, 1'b0, 5'd8, 1'b1, 2'b00, 3'b000, 32'h0000_00AB, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_outputs("first_after_rst", 1'b1, 32'h0000_00AB, 5'd8, 1'b0);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        check("first_after_rst.instret", instret, 64'd1);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        check("wrap.preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd3, 1'b1, 2'b00, 3'b000, 32'h0000_0001, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        check("wrap.instret", instret, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
